// File: rtl/ps2_keycode_stream.sv
// PS/2 keyboard front end: filtered line sampling, frame deserialiser, E0/F0 prefix decode, event FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity fails; otherwise the parity bit is ignored.
module ps2_keycode_stream #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_US  = 100,
  parameter int FIFO_DEPTH  = 4,
  parameter int HIST_BYTES  = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    ps2_clk,
  input  logic                    ps2_data,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [7:0]              evt_code,
  output logic                    evt_break,
  output logic                    evt_ext,
  output logic [8*HIST_BYTES-1:0] history,
  output logic                    frame_err,
  output logic                    overflow
);

  localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]         raw, meta, sync, filt;
  logic [1:0][FW-1:0] flt_cnt;
  logic               clk_d, fall;
  state_t             state, state_nxt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic [TW-1:0]      tmo_cnt;
  logic               timeout, frame_ok, accept, reject;
  logic               vld_p0;
  logic [7:0]         byte_p0;
  logic               ext_flag, brk_flag;
  logic               is_e0, is_f0, push, pop, push_ok;
  logic [9:0]         push_evt, head;
  logic [9:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;

  // Input stage: bit 0 is the PS/2 clock, bit 1 the PS/2 data
  assign raw = {ps2_data, ps2_clk};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= 2'b11;
      sync <= 2'b11;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // A filtered line only follows its input after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      filt    <= 2'b11;
      flt_cnt <= '0;
      clk_d   <= 1'b1;
    end else begin
      clk_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == FLT_MAX) begin
          filt[i]    <= sync[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall    = clk_d & ~filt[0];
  assign timeout = (state != IDLE) && !fall && (tmo_cnt == TMO_MAX);

  // Frame FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!filt[1]) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    accept = 1'b0;
    reject = 1'b0;
    if (timeout) begin
      reject = 1'b1;
    end else if (fall && state == STOP) begin
      if (frame_ok) accept = 1'b1;
      else          reject = 1'b1;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_acc;

  // Running XOR of data and parity bits; a valid frame leaves it at 1
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      par_acc <= 1'b0;
    end else if (fall) begin
      if (state == IDLE)                          par_acc <= 1'b0;
      else if (state == DATA || state == PARITY)  par_acc <= par_acc ^ filt[1];
    end
  end

  assign frame_ok = filt[1] & par_acc;
`else
  assign frame_ok = filt[1];
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (fall || state == IDLE)  tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
      if (fall) begin
        if (state == IDLE) begin
          bit_cnt <= '0;
        end else if (state == DATA) begin
          shreg   <= {filt[1], shreg[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Stage p0: accepted byte and error pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p0    <= 1'b0;
      byte_p0   <= '0;
      frame_err <= 1'b0;
    end else begin
      vld_p0    <= accept;
      frame_err <= reject;
      if (accept) byte_p0 <= shreg;
    end
  end

  assign is_e0    = (byte_p0 == 8'hE0);
  assign is_f0    = (byte_p0 == 8'hF0);
  assign push     = vld_p0 & ~is_e0 & ~is_f0;
  assign push_evt = {ext_flag, brk_flag, byte_p0};

  // Stage p1: prefix decode, history and FIFO write
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      history  <= '0;
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (vld_p0) begin
      history <= {history[8*HIST_BYTES-9:0], byte_p0};
      if (is_e0) begin
        ext_flag <= 1'b1;
      end else if (is_f0) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  assign evt_valid = (count != '0);
  assign pop       = evt_valid & evt_ready;
  assign push_ok   = push & ((count != DEPTH_C) | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_evt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & ~push_ok;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head fields read as zero while the FIFO is empty
  assign head      = mem[rd_ptr];
  assign evt_code  = evt_valid ? head[7:0] : 8'h00;
  assign evt_break = evt_valid & head[8];
  assign evt_ext   = evt_valid & head[9];

endmodule

// File: tb/tb_ps2_keycode_stream.sv
// Self-checking bench for ps2_keycode_stream: PS/2 frames driven bit by bit, events checked
// against a byte-level model of prefix decode, history and a bounded event queue.
`timescale 1ns/1ps
module tb_ps2_keycode_stream;

  localparam int CLK_FREQ_HZ = 10_000_000;
  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_US  = 100;
  localparam int FIFO_DEPTH  = 4;
  localparam int HIST_BYTES  = 4;
  localparam int HP          = 20;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        evt_ready = 1'b1;
  logic        evt_valid, evt_break, evt_ext, frame_err, overflow;
  logic [7:0]  evt_code;
  logic [31:0] history;

  ps2_keycode_stream #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ), .FILTER_LEN(FILTER_LEN), .TIMEOUT_US(TIMEOUT_US),
    .FIFO_DEPTH(FIFO_DEPTH), .HIST_BYTES(HIST_BYTES)
  ) dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_break(evt_break), .evt_ext(evt_ext), .history(history),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #50 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [9:0]  obs_q[$];
  logic [9:0]  exp_q[$];
  int          obs_ferr = 0, obs_ovf = 0, exp_ferr = 0, exp_ovf = 0;
  logic [31:0] m_hist = '0;
  logic        m_ext = 1'b0, m_brk = 1'b0;
  bit          m_stall = 1'b0;
  bit          rand_done;

  always @(negedge clk) begin
    if (resetn) begin
      if (evt_valid && evt_ready) obs_q.push_back({evt_ext, evt_break, evt_code});
      if (frame_err) obs_ferr++;
      if (overflow)  obs_ovf++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: what the keyboard interface must do with one accepted byte
  task automatic model_byte(input logic [7:0] b);
    m_hist = {m_hist[23:0], b};
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (m_stall && exp_q.size() == FIFO_DEPTH) exp_ovf++;
      else exp_q.push_back({m_ext, m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(HP);
    ps2_clk = 1'b0;
    tick(HP);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
    logic [10:0] bits;
    bit good;
    bits = {stop, ~(^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
    ps2_data = 1'b1;
    tick(4 * HP);
    good = stop;
`ifdef PS2_PARITY_CHECK_EN
    if (par_flip) good = 1'b0;
`endif
    if (good) model_byte(b);
    else exp_ferr++;
  endtask

  task automatic do_reset();
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    resetn   = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(4);
    m_hist = '0; m_ext = 1'b0; m_brk = 1'b0;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    tick(3);
    n_checks++;
    if ({evt_valid, evt_code, evt_break, evt_ext, history, frame_err, overflow} !== '0)
      $display("FAIL reset_hold: got valid=%b code=%h hist=%h ferr=%b ovf=%b required all 0",
               evt_valid, evt_code, history, frame_err, overflow);
    else n_pass++;
    resetn = 1'b1;
    tick(5);
    n_checks++;
    if ({evt_valid, evt_code, evt_break, evt_ext, history, frame_err, overflow} !== '0)
      $display("FAIL reset_release: got valid=%b code=%h hist=%h required all 0", evt_valid, evt_code, history);
    else n_pass++;
  endtask

  task automatic test_single();
    send_frame(8'h1C, 1'b0, 1'b1);
    n_checks++;
    if (obs_q.size() != 1) $display("FAIL single_count: got %0d events required 1", obs_q.size());
    else n_pass++;
    n_checks++;
    if (obs_q.size() < 1 || obs_q[0] !== 10'h01C) $display("FAIL single_event: got %h required 01c", obs_q.size() ? obs_q[0] : 10'h3FF);
    else n_pass++;
    n_checks++;
    if (history !== 32'h0000001C) $display("FAIL single_hist: got %h required 0000001c", history);
    else n_pass++;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_prefix();
    do_reset();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL prefix_early: got %0d events required 0", obs_q.size());
    else n_pass++;
    send_frame(8'h75, 1'b0, 1'b1);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 10'h375) $display("FAIL prefix_event: got n=%0d first=%h required 1 x 375", obs_q.size(), obs_q.size() ? obs_q[0] : 10'h000);
    else n_pass++;
    n_checks++;
    if (history !== 32'h00E0F075) $display("FAIL prefix_hist: got %h required 00e0f075", history);
    else n_pass++;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_parity();
    logic [31:0] h0;
    int f0;
    h0 = history;
    f0 = obs_ferr;
    send_frame(8'h1C, 1'b1, 1'b1);
    n_checks++;
    if (obs_q.size() != exp_q.size() || (exp_q.size() > 0 && obs_q[0] !== exp_q[0]))
      $display("FAIL parity_event: got n=%0d required n=%0d", obs_q.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (obs_ferr !== exp_ferr) $display("FAIL parity_ferr: got %0d pulses required %0d", obs_ferr, exp_ferr);
    else n_pass++;
    n_checks++;
    if (history !== m_hist) $display("FAIL parity_hist: got %h required %h (before %h, ferr before %0d)", history, m_hist, h0, f0);
    else n_pass++;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bad_stop();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0);
    n_checks++;
    if (obs_ferr !== exp_ferr) $display("FAIL stop_ferr: got %0d pulses required %0d", obs_ferr, exp_ferr);
    else n_pass++;
    n_checks++;
    if (history !== m_hist) $display("FAIL stop_hist: got %h required %h", history, m_hist);
    else n_pass++;
    send_frame(8'h6B, 1'b0, 1'b1);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 10'h26B) $display("FAIL stop_keeps_ext: got n=%0d first=%h required 1 x 26b", obs_q.size(), obs_q.size() ? obs_q[0] : 10'h000);
    else n_pass++;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    int f0;
    f0 = obs_ferr;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    tick(1200);
    exp_ferr++;
    n_checks++;
    if (obs_ferr !== f0 + 1) $display("FAIL timeout_ferr: got %0d pulses required %0d", obs_ferr - f0, 1);
    else n_pass++;
    send_frame(8'h29, 1'b0, 1'b1);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 10'h029) $display("FAIL timeout_next: got n=%0d first=%h required 1 x 029", obs_q.size(), obs_q.size() ? obs_q[0] : 10'h000);
    else n_pass++;
    n_checks++;
    if (obs_ferr !== exp_ferr) $display("FAIL timeout_total: got %0d pulses required %0d", obs_ferr, exp_ferr);
    else n_pass++;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    int o0;
    codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    o0 = obs_ovf;
    evt_ready = 1'b0;
    m_stall = 1'b1;
    for (int i = 0; i < 5; i++) send_frame(codes[i], 1'b0, 1'b1);
    n_checks++;
    if (obs_ovf !== o0 + 1) $display("FAIL ovf_pulse: got %0d pulses required 1", obs_ovf - o0);
    else n_pass++;
    n_checks++;
    if (evt_valid !== 1'b1 || evt_code !== 8'h1C) $display("FAIL ovf_head: got valid=%b code=%h required 1/1c", evt_valid, evt_code);
    else n_pass++;
    evt_ready = 1'b1;
    m_stall = 1'b0;
    tick(12);
    n_checks++;
    if (obs_q.size() != 4) $display("FAIL ovf_drain_count: got %0d required 4", obs_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) $display("FAIL ovf_order_%0d: got %h required %h", i, (i < obs_q.size()) ? obs_q[i] : 10'h3FF, exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (evt_valid !== 1'b0) $display("FAIL ovf_empty: got valid=%b required 0", evt_valid);
    else n_pass++;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    int f0;
    f0 = obs_ferr;
    ps2_data = 1'b0;
    tick(4);
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(4);
    ps2_data = 1'b1;
    tick(20);
    send_frame(8'h33, 1'b0, 1'b1);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 10'h033) $display("FAIL glitch_event: got n=%0d first=%h required 1 x 033", obs_q.size(), obs_q.size() ? obs_q[0] : 10'h000);
    else n_pass++;
    n_checks++;
    if (obs_ferr !== f0) $display("FAIL glitch_ferr: got %0d pulses required 0", obs_ferr - f0);
    else n_pass++;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop;
    int         r;
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          r = $urandom_range(0, 7);
          b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : (r == 2) ? 8'hE1 : 8'($urandom);
          stop = ($urandom_range(0, 7) != 0);
          send_frame(b, 1'b0, stop);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          evt_ready = 1'($urandom);
          tick(1);
        end
      end
    join
    evt_ready = 1'b1;
    tick(20);
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d required %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) $display("FAIL rand_evt_%0d: got %h required %h", i, (i < obs_q.size()) ? obs_q[i] : 10'h3FF, exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (history !== m_hist) $display("FAIL rand_hist: got %h required %h", history, m_hist);
    else n_pass++;
    n_checks++;
    if (obs_ferr !== exp_ferr || obs_ovf !== exp_ovf) $display("FAIL rand_pulses: got ferr=%0d ovf=%0d required ferr=%0d ovf=%0d", obs_ferr, obs_ovf, exp_ferr, exp_ovf);
    else n_pass++;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    int f0;
    send_frame(8'h4D, 1'b0, 1'b1);
    obs_q.delete(); exp_q.delete();
    f0 = obs_ferr;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    resetn = 1'b0;
    tick(2);
    n_checks++;
    if ({evt_valid, evt_code, evt_break, evt_ext, history, frame_err, overflow} !== '0)
      $display("FAIL midreset_outputs: got valid=%b code=%h hist=%h ferr=%b ovf=%b required all 0",
               evt_valid, evt_code, history, frame_err, overflow);
    else n_pass++;
    do_reset();
    send_frame(8'h1C, 1'b0, 1'b1);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 10'h01C || history !== 32'h0000001C)
      $display("FAIL midreset_next: got n=%0d hist=%h required 1 event, hist 0000001c", obs_q.size(), history);
    else n_pass++;
    n_checks++;
    if (obs_ferr !== f0) $display("FAIL midreset_ferr: got %0d pulses required 0", obs_ferr - f0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_parity();
    test_bad_stop();
    test_timeout();
    test_overflow();
    test_glitch();
    test_random();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
